// File: rtl/inst_loader.sv
// Instruction-memory loader: assembles a length-prefixed little-endian byte
// stream into 32-bit words and writes them to the instruction BRAM, holding the core in reset while busy.
module inst_loader #(
  parameter int unsigned DEPTH = 32000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] word_cnt
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_idx_q, word_idx_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        xfer;
  logic [31:0] assembled;

  assign rx_ready  = (state_q == LEN) || (state_q == DATA);
  assign busy      = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign word_cnt  = word_cnt_q;
  assign xfer      = rx_valid && rx_ready;

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    word_cnt_d  = word_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // Word as it will look once the incoming byte lands in its lane.
    assembled = shift_q;
    assembled[8*byte_idx_q +: 8] = rx_data;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN;
          byte_idx_d = 2'd0;
          word_idx_d = 32'd0;
          word_cnt_d = 32'd0;
        end
      end
      LEN: begin
        if (xfer) begin
          shift_d    = assembled;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            len_d = assembled;
            if (assembled == 32'd0)           state_d = DONE;
            else if (assembled > 32'(DEPTH))  state_d = ERR;
            else                              state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          shift_d    = assembled;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = {word_idx_q[29:0], 2'b00};
            mem_wdata_d = assembled;
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 32'd1;
        word_cnt_d = word_cnt_q + 32'd1;
        state_d    = (word_idx_q + 32'd1 == len_q) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_idx_q  <= 2'd0;
      shift_q     <= 32'd0;
      len_q       <= 32'd0;
      word_idx_q  <= 32'd0;
      word_cnt_q  <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      word_cnt_q  <= word_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: the stimulus side pushes expected writes,
// an independent monitor pops and checks every mem_we it sees.
module tb_inst_loader;
  localparam int unsigned DEPTH = 32000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, word_cnt;

  inst_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  int          wtimes[$];
  logic [31:0] wq[$];
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  initial forever begin
    @(negedge clk);
    if (mem_we === 1'b1) begin
      chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_e[63:32]);
        chk("wr_data", mem_wdata, mon_e[31:0]);
        $display("write addr=%h data=%h cyc=%0d", mem_addr, mem_wdata, cyc);
      end
      wtimes.push_back(cyc);
    end
  end

  // Present one byte after 'gap' idle cycles; returns at the negedge after it transfers.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit st);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    start    = st;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_timeout: got rx_ready 0 expected 1 within 50 cycles");
    end
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  // Full load of length 'len' using words from wq; checks final status.
  task automatic run_load(input logic [31:0] len, input int gap, input bit noise);
    bit legal;
    logic [31:0] w;
    wtimes.delete();
    legal = (len != 0) && (len <= DEPTH);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("ready_after_start", {31'd0, rx_ready}, 32'd1);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gap, 1'b0);
    if (legal) begin
      for (int k = 0; k < int'(len); k++) begin
        w = wq[k];
        exp_q.push_back({32'(k) << 2, w});
        for (int i = 0; i < 4; i++)
          send_byte(w[8*i +: 8], gap, noise && ($urandom_range(0, 3) == 0));
      end
      @(negedge clk);
    end
    chk("done", {31'd0, done}, (len <= DEPTH) ? 32'd1 : 32'd0);
    chk("err", {31'd0, err}, (len > DEPTH) ? 32'd1 : 32'd0);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("ready_end", {31'd0, rx_ready}, 32'd0);
    chk("word_cnt", word_cnt, legal ? len : 32'd0);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    if (gap == 0 && legal && len >= 2) begin
      for (int i = 1; i < wtimes.size(); i++)
        chk("word_period", 32'(wtimes[i] - wtimes[i-1]), 32'd5);
    end
    $display("load len=%0d gap=%0d noise=%0d done=%0d err=%0d word_cnt=%0d", len, gap, noise, done, err, word_cnt);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] len;
    int r;
    // Reset state
    #12;
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_word_cnt", word_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", {31'd0, rx_ready}, 32'd0);

    // Two-word load, held valid
    wq = '{32'h00000013, 32'h00100093};
    run_load(32'd2, 0, 1'b0);
    // Zero length
    run_load(32'd0, 0, 1'b0);
    // Oversize DEPTH+1, then a valid start clears err
    run_load(32'(DEPTH) + 32'd1, 0, 1'b0);
    wq = '{32'h00000013, 32'h00100093};
    run_load(32'd2, 2, 1'b1);
    run_load(32'h80000000, 0, 1'b0);

    // Reset mid-load after the 2nd data byte of word 1
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len = 32'd2;
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, rx_ready}, 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_word_cnt", word_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_ready", {31'd0, rx_ready}, 32'd0);
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    wq = '{32'hCAFEF00D, 32'h12345678, 32'h0BADBEEF};
    run_load(32'd3, 0, 1'b0);

    // Randomized loads
    for (int t = 0; t < 14; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      len = 32'd0;
      else if (r == 1) len = 32'(DEPTH) + 32'd1 + 32'($urandom_range(0, 1000));
      else if (r == 2) len = 32'hFFFFFFFF;
      else             len = 32'($urandom_range(1, 5));
      wq.delete();
      for (int k = 0; k < 5; k++) wq.push_back($urandom);
      run_load(len, 2 * $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
# inst_loader

Byte-stream instruction memory loader: the write side of the instruction BRAM that the fetch stage reads. It accepts a length-prefixed little-endian byte stream, for example from a UART receiver or a test harness. It assembles 32-bit instruction words and issues one word write per instruction to the instruction memory's write port. While a load is in progress it holds the core in reset through `busy`, and it reports completion or error.

## Interface
Parameters:
- DEPTH, 32000, instruction memory depth in 32-bit words; the maximum legal load length.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy.
- rx_data  in  8  incoming stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle. A byte transfers when rx_valid && rx_ready.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write, always word-aligned (word_idx << 2), matching the fetch stage's addr >> 2 indexing.
- mem_wdata  out  32  instruction word to write.
- busy  out  1  load in progress; used to hold the core in reset.
- done  out  1  last load completed successfully; sticky.
- err  out  1  last load rejected because its length exceeded DEPTH; sticky.
- word_cnt  out  32  number of words written in the current or last load.

## Operation
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE: rx_ready=0, busy=0.
  - start → LEN; clears done, err, word_cnt, byte_idx and word_idx.
- DONE and ERR: behave as IDLE, except they keep done or err high.
  - start → LEN with the same clears.
- LEN: rx_ready=1.
  - Each transferred byte is placed at bits [8*byte_idx +: 8] of the shift register (little-endian), then byte_idx increments mod 4.
  - On the 4th byte, the assembled word is latched into len:
    - len==0 → DONE
    - len>DEPTH → ERR
    - otherwise → DATA
- DATA: rx_ready=1. Bytes are assembled the same way.
  - On the 4th byte → WRITE.
- WRITE: rx_ready=0, mem_we=1, mem_addr=word_idx<<2, mem_wdata=assembled word.
  - word_idx and word_cnt increment.
  - If the new word_idx==len → DONE, else → DATA.
- busy=1 in LEN, DATA and WRITE.
- start is ignored in LEN, DATA and WRITE.
- Bytes presented while rx_ready=0 are not consumed; the source must hold them.
- Extra bytes after the final word are never accepted, because rx_ready=0 outside LEN and DATA.

## Timing
- Reset (asynchronous): state=IDLE; rx_ready, mem_we, busy, done and err are 0; mem_addr, mem_wdata and word_cnt are 0; internal counters are 0.
- start sampled at cycle t → rx_ready=1 at t+1.
- rx_ready is decoded combinationally from state.
- mem_we, mem_addr and mem_wdata are registered. mem_we is high for exactly the one cycle after the 4th byte of a word transfers.
- With rx_valid held high, the minimum word period is 5 cycles: 4 byte transfers plus 1 WRITE.
- done or err rises on the cycle after the final WRITE, or after the 4th length byte, and stays high until the next start or rst.
- busy falls in the same cycle that done or err rises.
- Reset mid-load aborts immediately and takes effect on the same edge. Words already written stay in memory; there is no rollback, and no further mem_we is issued.
- Lengths are compared as 32-bit unsigned values. word_idx never exceeds len, so mem_addr never reaches DEPTH*4.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately; after release, state IDLE and rx_ready=0.
- Two-word load: start, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 with rx_valid held high → mem_we at addr 0x0 with data 0x00000013, then at addr 0x4 with data 0x00100093, 5 cycles apart. Then done=1, busy=0, word_cnt=2.
- Zero length: start, then bytes 00 00 00 00 → done=1 on the next cycle, no mem_we, word_cnt=0.
- Oversize: length DEPTH+1 (for DEPTH=32000, bytes 01 7D 00 00) → err=1, done=0, no mem_we, rx_ready=0 afterwards. A following valid start clears err.
- Gapped stream and backpressure: rx_valid high only every third cycle → writes identical to the two-word case. During WRITE, rx_ready=0 and the held byte is consumed on the next cycle. start pulses mid-load are ignored.
- Reset mid-load: assert rst after the 2nd data byte of word 1 → no mem_we is ever issued. A fresh load then writes again starting at addr 0x0.
